// File: rtl/opr_sequencer.sv
// -----------------------------------------------------------------------------
// opr_sequencer
//
// Executes PDP-8 OPR (opcode 7) instructions on behalf of the CPU control unit.
// A request is captured in IDLE, evaluated in EXEC with help from an external
// combinational micro-instruction decoder, and written back in WB, where the
// architectural outputs update together with a one-cycle done pulse.
// This block owns the halt flag.
//
// Optional feature (compile-time macro OPR_GROUP3_MQ_EN):
//   defined   : MQ register present, group 3 CLA / MQA / MQL / SWP supported.
//   undefined : no MQ register, mq_out reads 0, group 3 honours only CLA.
//
// Parameters
//   WORD_W     width of AC / PC / MQ / SR (12 for a PDP-8)
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   op_valid / op_ready   request handshake (op_ready = IDLE and not halted)
//   op_ir                 full 12-bit instruction word
//   pc_in                 PC already incremented past this instruction
//   ac_in, l_in           current accumulator and link
//   sr_in                 front-panel switch register
//   cont                  continue pulse; clears halt while idle
//   dec_ireg/ac/l         operands driven to the micro-instruction decoder
//   dec_ac_mi/l_mi/skip   decoder results (sampled only in EXEC)
//   dec_g1/g2/g3          decoder group flags (sampled only in EXEC)
//   done                  one-cycle pulse; result outputs valid
//   ac_out/l_out/pc_out/mq_out  results, held until the next done
//   halt                  sticky halt flag
//   illegal               valid with done: op_ir[11:9] was not 7
// -----------------------------------------------------------------------------
module opr_sequencer #(
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [11:0]       op_ir,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] ac_in,
  input  logic              l_in,
  input  logic [WORD_W-1:0] sr_in,
  input  logic              cont,
  output logic [8:0]        dec_ireg,
  output logic [WORD_W-1:0] dec_ac,
  output logic              dec_l,
  input  logic [WORD_W-1:0] dec_ac_mi,
  input  logic              dec_l_mi,
  input  logic              dec_skip,
  input  logic              dec_g1,
  input  logic              dec_g2,
  input  logic              dec_g3,
  output logic              done,
  output logic [WORD_W-1:0] ac_out,
  output logic              l_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] mq_out,
  output logic              halt,
  output logic              illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state_reg;

  // Operands captured at accept; they feed the decoder for the whole op so
  // the requester is free to change its inputs after the handshake.
  logic [11:0]       ir_reg;
  logic [WORD_W-1:0] ac_cap_reg;
  logic [WORD_W-1:0] pc_cap_reg;
  logic [WORD_W-1:0] sr_cap_reg;
  logic              l_cap_reg;

  // Results computed in EXEC, committed to the outputs in WB.
  logic [WORD_W-1:0] ac_res_reg;
  logic [WORD_W-1:0] pc_res_reg;
  logic              l_res_reg;
  logic              halt_res_reg;
  logic              illegal_res_reg;

  // Architectural / output registers.
  logic [WORD_W-1:0] ac_out_reg;
  logic [WORD_W-1:0] pc_out_reg;
  logic              l_out_reg;
  logic              done_reg;
  logic              halt_reg;
  logic              illegal_reg;

`ifdef OPR_GROUP3_MQ_EN
  logic [WORD_W-1:0] mq_reg;
  logic [WORD_W-1:0] mq_res_reg;
  logic [WORD_W-1:0] mq_next;
`endif

  // EXEC-stage combinational results.
  logic [WORD_W-1:0] ac_cla;
  logic [WORD_W-1:0] ac_g2;
  logic [WORD_W-1:0] ac_next;
  logic [WORD_W-1:0] pc_next;
  logic              l_next;
  logic              skip_next;
  logic              halt_next;
  logic              illegal_next;

  // CLA (IR[7]) is applied first in both group 2 and group 3.
  assign ac_cla = ir_reg[7] ? '0 : ac_cap_reg;

  // Group 2 OSR: OR the switch register into the (possibly cleared) AC.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_osr
      assign ac_g2[gi] = ac_cla[gi] | (ir_reg[2] & sr_cap_reg[gi]);
    end
  endgenerate

  // Decoder inputs only matter in EXEC, and only the EXEC branch of the FSM
  // loads anything derived from this block, so X on the decoder outputs in
  // other states cannot reach architectural state.
  always_comb begin
    illegal_next = (ir_reg[11:9] != 3'o7);
    ac_next      = ac_cap_reg;
    l_next       = l_cap_reg;
    skip_next    = 1'b0;
    halt_next    = 1'b0;
`ifdef OPR_GROUP3_MQ_EN
    mq_next      = mq_reg;
`endif
    if (!illegal_next) begin
      if (dec_g1) begin
        ac_next = dec_ac_mi;
        l_next  = dec_l_mi;
      end else if (dec_g2) begin
        // Decoder evaluates skip on the captured, pre-CLA accumulator.
        skip_next = dec_skip;
        ac_next   = ac_g2;
        halt_next = ir_reg[1];
      end else if (dec_g3) begin
`ifdef OPR_GROUP3_MQ_EN
        case ({ir_reg[6], ir_reg[4]})
          2'b11: begin
            ac_next = mq_reg;
            mq_next = ac_cla;
          end
          2'b10: ac_next = ac_cla | mq_reg;
          2'b01: begin
            mq_next = ac_cla;
            ac_next = '0;
          end
          default: ac_next = ac_cla;
        endcase
`else
        ac_next = ac_cla;
`endif
      end
    end
    // Skip adds one to the already-incremented PC; wraps modulo 2^WORD_W.
    pc_next = pc_cap_reg + {{(WORD_W-1){1'b0}}, skip_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      ir_reg          <= '0;
      ac_cap_reg      <= '0;
      pc_cap_reg      <= '0;
      sr_cap_reg      <= '0;
      l_cap_reg       <= 1'b0;
      ac_res_reg      <= '0;
      pc_res_reg      <= '0;
      l_res_reg       <= 1'b0;
      halt_res_reg    <= 1'b0;
      illegal_res_reg <= 1'b0;
      ac_out_reg      <= '0;
      pc_out_reg      <= '0;
      l_out_reg       <= 1'b0;
      done_reg        <= 1'b0;
      halt_reg        <= 1'b0;
      illegal_reg     <= 1'b0;
`ifdef OPR_GROUP3_MQ_EN
      mq_reg          <= '0;
      mq_res_reg      <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Continue only acts while idle; with halt clear it is a no-op.
          if (cont) begin
            halt_reg <= 1'b0;
          end
          // Same condition as op_ready, evaluated on the current halt flag.
          if (op_valid && !halt_reg) begin
            ir_reg     <= op_ir;
            ac_cap_reg <= ac_in;
            l_cap_reg  <= l_in;
            pc_cap_reg <= pc_in;
            sr_cap_reg <= sr_in;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          ac_res_reg      <= ac_next;
          l_res_reg       <= l_next;
          pc_res_reg      <= pc_next;
          halt_res_reg    <= halt_next;
          illegal_res_reg <= illegal_next;
`ifdef OPR_GROUP3_MQ_EN
          mq_res_reg      <= mq_next;
`endif
          state_reg       <= ST_WB;
        end
        ST_WB: begin
          ac_out_reg  <= ac_res_reg;
          l_out_reg   <= l_res_reg;
          pc_out_reg  <= pc_res_reg;
          illegal_reg <= illegal_res_reg;
`ifdef OPR_GROUP3_MQ_EN
          mq_reg      <= mq_res_reg;
`endif
          // cont is not looked at here, so an HLT always wins over it.
          if (halt_res_reg) begin
            halt_reg <= 1'b1;
          end
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign op_ready = (state_reg == ST_IDLE) && !halt_reg;
  assign dec_ireg = ir_reg[8:0];
  assign dec_ac   = ac_cap_reg;
  assign dec_l    = l_cap_reg;
  assign done     = done_reg;
  assign ac_out   = ac_out_reg;
  assign l_out    = l_out_reg;
  assign pc_out   = pc_out_reg;
  assign halt     = halt_reg;
  assign illegal  = illegal_reg;
`ifdef OPR_GROUP3_MQ_EN
  assign mq_out   = mq_reg;
`else
  assign mq_out   = '0;
`endif

endmodule
